// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the operand source and the sequential ALU.
// The master drives the request; the ALU (slave) returns status and result.
interface alu_seq_unit_if #(
  parameter int WIDTH = 5
);
  logic                   start;
  logic [1:0]             op;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;
  logic [WIDTH-1:0]       remainder;
  logic                   flag;

  modport master (
    output start, op, a, b,
    input  busy, done, result, remainder, flag
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, remainder, flag
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered-operand unsigned ALU: single-cycle add/sub, bit-serial shift-add
// multiply and restoring divide, with start/busy/done handshake.
module alu_seq_unit #(
  parameter int WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [1:0]        op_q,     op_d;
  logic [W2-1:0]     opa_q,    opa_d;
  logic [WIDTH-1:0]  opb_q,    opb_d;
  logic [W2-1:0]     acc_q,    acc_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic              dz_q,     dz_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [W2-1:0]     result_q, result_d;
  logic [WIDTH-1:0]  rem_q,    rem_d;
  logic              flag_q,   flag_d;

  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  diff_s;
  logic [W2-1:0]     mul_acc_s;
  logic [WIDTH:0]    div_shift_s;
  logic              div_ge_s;
  logic [WIDTH-1:0]  div_rem_s;
  logic [WIDTH-1:0]  div_quo_s;

  // Datapath step for the current EXEC cycle, evaluated every cycle from the latched operands.
  always_comb begin
    sum_s       = {1'b0, opa_q[WIDTH-1:0]} + {1'b0, opb_q};
    diff_s      = opa_q[WIDTH-1:0] - opb_q;
    mul_acc_s   = acc_q + (opb_q[0] ? opa_q : {W2{1'b0}});
    // Restoring divide: partial remainder in acc_q low bits, dividend/quotient shifts through opa_q.
    div_shift_s = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opb_q});
    div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - opb_q) : div_shift_s[WIDTH-1:0];
    div_quo_s   = {opa_q[WIDTH-2:0], div_ge_s};
  end

  // Next-state and next-output decode for the IDLE/EXEC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_EXEC;
          busy_d  = 1'b1;
          op_d    = bus.op;
          opa_d   = {{WIDTH{1'b0}}, bus.a};
          opb_d   = bus.b;
          acc_d   = {W2{1'b0}};
          cnt_d   = CNT_LOAD;
          dz_d    = (bus.op == OP_DIV) && (bus.b == {WIDTH{1'b0}});
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = {{(W2-WIDTH-1){1'b0}}, sum_s};
            rem_d    = {WIDTH{1'b0}};
            flag_d   = sum_s[WIDTH];
          end
          OP_SUB: begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = {{WIDTH{1'b0}}, diff_s};
            rem_d    = {WIDTH{1'b0}};
            flag_d   = (opa_q[WIDTH-1:0] < opb_q);
          end
          OP_MUL: begin
            acc_d = mul_acc_s;
            opa_d = opa_q << 1'b1;
            opb_d = opb_q >> 1'b1;
            if (cnt_q == {CW{1'b0}}) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = mul_acc_s;
              rem_d    = {WIDTH{1'b0}};
              flag_d   = 1'b0;
            end else begin
              cnt_d  = cnt_q - CW'(1);
              busy_d = 1'b1;
            end
          end
          OP_DIV: begin
            if (dz_q) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              rem_d    = opa_q[WIDTH-1:0];
              flag_d   = 1'b1;
            end else begin
              acc_d = {{WIDTH{1'b0}}, div_rem_s};
              opa_d = {{WIDTH{1'b0}}, div_quo_s};
              if (cnt_q == {CW{1'b0}}) begin
                state_d  = S_DONE;
                done_d   = 1'b1;
                result_d = {{WIDTH{1'b0}}, div_quo_s};
                rem_d    = div_rem_s;
                flag_d   = 1'b0;
              end else begin
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      opa_q    <= {W2{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      acc_q    <= {W2{1'b0}};
      cnt_q    <= {CW{1'b0}};
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {W2{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = rem_q;
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at WIDTH=5.
module tb_alu_seq_unit;

  localparam int WIDTH = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one op, count EXEC cycles via busy, then check the DONE pulse and outputs.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [4:0] a, input logic [4:0] b,
                        input int exp_cyc, input logic [31:0] exp_res,
                        input logic [31:0] exp_rem, input logic exp_flag,
                        input bit disturb);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      chk({tag, " done_low_in_exec"}, {31'd0, bus.done}, 32'd0);
      n++;
      if (disturb && n == 2) begin
        bus.start = 1'b1; bus.a = 5'd0; bus.b = 5'd0; bus.op = 2'b00;
      end
      if (disturb && n == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    chk({tag, " exec_cycles"}, n, exp_cyc);
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, " result"}, {22'd0, bus.result}, exp_res);
    chk({tag, " remainder"}, {27'd0, bus.remainder}, exp_rem);
    chk({tag, " flag"}, {31'd0, bus.flag}, {31'd0, exp_flag});
    @(negedge clk);
    chk({tag, " done_single_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " result_hold"}, {22'd0, bus.result}, exp_res);
  endtask

  initial begin
    logic [4:0] ba [3];
    logic [4:0] bb [3];
    ba = '{5'd6, 5'd10, 5'd20};
    bb = '{5'd4, 5'd5, 5'd11};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = 5'd0; bus.b = 5'd0;
    rst_n = 1'b0;
    #12;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", {22'd0, bus.result}, 32'd0);
    chk("reset remainder", {27'd0, bus.remainder}, 32'd0);
    chk("reset flag", {31'd0, bus.flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_1_2",   2'b00, 5'd1,  5'd2,  1, 32'd3,   32'd0, 1'b0, 1'b0);
    run_op("add_31_1",  2'b00, 5'd31, 5'd1,  1, 32'd32,  32'd0, 1'b1, 1'b0);
    run_op("sub_1_2",   2'b01, 5'd1,  5'd2,  1, 32'd31,  32'd0, 1'b1, 1'b0);
    run_op("sub_2_1",   2'b01, 5'd2,  5'd1,  1, 32'd1,   32'd0, 1'b0, 1'b0);
    run_op("mul_31_31", 2'b10, 5'd31, 5'd31, 5, 32'd961, 32'd0, 1'b0, 1'b1);
    run_op("mul_6_5",   2'b10, 5'd6,  5'd5,  5, 32'd30,  32'd0, 1'b0, 1'b0);
    run_op("div_17_3",  2'b11, 5'd17, 5'd3,  5, 32'd5,   32'd2, 1'b0, 1'b0);
    run_op("div_5_17",  2'b11, 5'd5,  5'd17, 5, 32'd0,   32'd5, 1'b0, 1'b0);
    run_op("div_31_1",  2'b11, 5'd31, 5'd1,  5, 32'd31,  32'd0, 1'b0, 1'b0);
    run_op("div_9_0",   2'b11, 5'd9,  5'd0,  1, 32'd31,  32'd9, 1'b1, 1'b0);
    run_op("add_3_4",   2'b00, 5'd3,  5'd4,  1, 32'd7,   32'd0, 1'b0, 1'b0);

    // Back-to-back adds with start held high: EXEC, DONE, EXEC, DONE, ...
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = ba[0]; bus.b = bb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b busy", {31'd0, bus.busy}, 32'd1);
      chk("b2b done_low", {31'd0, bus.done}, 32'd0);
      chk("b2b result_hold", {22'd0, bus.result},
          (i == 0) ? 32'd7 : 32'(ba[i-1]) + 32'(bb[i-1]));
      @(negedge clk);
      chk("b2b done", {31'd0, bus.done}, 32'd1);
      chk("b2b busy_low", {31'd0, bus.busy}, 32'd0);
      chk("b2b result", {22'd0, bus.result}, 32'(ba[i]) + 32'(bb[i]));
      if (i < 2) begin
        bus.a = ba[i+1]; bus.b = bb[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b end busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b end done", {31'd0, bus.done}, 32'd0);
    chk("b2b end result", {22'd0, bus.result}, 32'd31);

    // Asynchronous reset during the third multiply EXEC cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 5'd31; bus.b = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstmul busy1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmul busy3", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmul busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmul done", {31'd0, bus.done}, 32'd0);
    chk("rstmul result", {22'd0, bus.result}, 32'd0);
    chk("rstmul remainder", {27'd0, bus.remainder}, 32'd0);
    chk("rstmul flag", {31'd0, bus.flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst busy", {31'd0, bus.busy}, 32'd0);
      chk("post_rst done", {31'd0, bus.done}, 32'd0);
    end
    run_op("add_2_2_after_rst", 2'b00, 5'd2, 5'd2, 1, 32'd4, 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised successor to the 5-bit switch-driven ALU: registered-operand unsigned ALU with a start/busy/done handshake.
- Add and subtract complete in one execute cycle. Multiply (shift-add) and divide (restoring) are iterative, one bit per clock.
- Sits between operand registers (switches/KEY decode) and the LED/seven-segment display logic; result is held stable for display until the next accepted start.

Parameters:
- WIDTH, 5, operand width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 add, 01 sub, 10 mul, 11 div; latched on accepted start.
- a  input  WIDTH  operand A, unsigned; latched on accepted start.
- b  input  WIDTH  operand B, unsigned; latched on accepted start.
- busy  output  1  high while in EXEC.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  2*WIDTH  sum / difference / product / quotient, zero-extended.
- remainder  output  WIDTH  divide remainder; 0 for other ops.
- flag  output  1  add: carry-out; sub: borrow (a<b); mul: 0; div: divide-by-zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, remainder=0, flag=0; internal counter and operand registers cleared. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, EXEC, DONE.
- IDLE: start=1 at an edge latches a, b, op, loads the iteration counter and moves to EXEC.
- EXEC latency:
  - Add/sub: exactly 1 cycle in EXEC.
  - Mul/div: exactly WIDTH cycles, counter WIDTH-1 down to 0; leave EXEC after the count-0 cycle.
- DONE: lasts one cycle; done=1, busy=0.
  - start=1 in DONE: accepted exactly as from IDLE (back-to-back; next EXEC follows directly).
  - Otherwise: go to IDLE.
- busy=1 exactly for cycles in EXEC. start, a, b and op changes during EXEC are ignored.
- result, remainder and flag update only on the edge entering DONE, then hold through IDLE until the next DONE. They are never changed while busy.
- Add: result = a+b (WIDTH+1 significant bits, upper bits 0); flag = bit WIDTH of the sum.
- Sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH, upper bits 0; flag = (a<b).
- Mul: product accumulated LSB-first shift-add over WIDTH iterations; result = a*b, full 2*WIDTH bits; flag=0.
- Div, b≠0: restoring division MSB-first over WIDTH iterations; result[WIDTH-1:0] = a/b, upper bits 0; remainder = a%b; flag=0.
- Div, b=0: detected at accept; EXEC lasts 1 cycle (not WIDTH); result[WIDTH-1:0] = all ones, upper bits 0; remainder = a; flag=1.
- No X on outputs at any time after reset; op values are exhaustively defined.
- done must not assert twice for one accepted start.

Test Plan (WIDTH=5):
- Add: reset, then start with a=1, b=2, op=00 -> busy exactly 1 cycle, done pulse next; result=3, flag=0. Repeat with a=31, b=1 -> result=32, flag=1.
- Sub: a=1, b=2, op=01 -> busy 1 cycle; result=31, flag=1. Then a=2, b=1 -> result=1, flag=0.
- Mul: a=31, b=31, op=10 -> busy exactly 5 cycles, then done; result=961, flag=0. Pulse start and change a/b mid-busy -> no effect on result or timing.
- Div: a=17, b=3, op=11 -> busy 5 cycles; result=5, remainder=2, flag=0. Then a=9, b=0 -> busy 1 cycle; result=31, remainder=9, flag=1.
- Back-to-back: hold start=1 with op=00 continuously -> pattern EXEC, DONE, EXEC, DONE…; done pulses every 2nd cycle; result holds between updates.
- Reset mid-mul: assert rst_n=0 at busy cycle 3 -> all outputs 0 immediately (asynchronously); after release, state IDLE, no done pulse until a new start.
